// File: rtl/knight_pkg.sv
// Shared types and default constants for the knight-rider speed controller.
package knight_pkg;

  localparam int unsigned KNIGHT_DIV_W = 24;

  localparam logic [KNIGHT_DIV_W-1:0] KNIGHT_MIN_DIV   = 24'h010000;
  localparam logic [KNIGHT_DIV_W-1:0] KNIGHT_MAX_DIV   = 24'hfff000;
  localparam logic [KNIGHT_DIV_W-1:0] KNIGHT_RESET_DIV = 24'h7fffff;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    AUTO_FAST = 2'd1,
    AUTO_SLOW = 2'd2
  } knight_ctrl_state_t;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, debounce counter and rising-edge press pulse for one button.
module button_debounce #(
  parameter int unsigned DEBOUNCE = 500000
) (
  input  logic clk_src,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a new level only after DEBOUNCE consecutive differing cycles.
  always_ff @(posedge clk_src) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE - 1)) begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/knight_speed_ctrl.sv
// Speed/mode controller: debounced buttons step the scanner divider, or an auto sweep does.
module knight_speed_ctrl
  import knight_pkg::*;
#(
  parameter int unsigned          WIDTH      = KNIGHT_DIV_W,
  parameter int unsigned          DEBOUNCE   = 500000,
  parameter int unsigned          DWELL      = 2000000,
  parameter logic [WIDTH-1:0]     MIN_DIV    = KNIGHT_MIN_DIV,
  parameter logic [WIDTH-1:0]     MAX_DIV    = KNIGHT_MAX_DIV,
  parameter logic [WIDTH-1:0]     RESET_DIV  = KNIGHT_RESET_DIV,
  parameter int unsigned          STEP_SHIFT = 3
) (
  input  logic             clk_src,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_auto,
  output logic [WIDTH-1:0] divider,
  output logic             div_update,
  output logic             auto_active
);

  localparam int unsigned XW = WIDTH + 1;
  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic press_up;
  logic press_dn;
  logic press_auto;

  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_up (
    .clk_src (clk_src),
    .reset   (reset),
    .btn     (btn_up),
    .press   (press_up)
  );

  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_down (
    .clk_src (clk_src),
    .reset   (reset),
    .btn     (btn_down),
    .press   (press_dn)
  );

  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_auto (
    .clk_src (clk_src),
    .reset   (reset),
    .btn     (btn_auto),
    .press   (press_auto)
  );

  knight_ctrl_state_t state;
  knight_ctrl_state_t state_nxt;
  logic [DW-1:0]      dwell_cnt;
  logic               dwell_tick;
  logic [WIDTH-1:0]   div_nxt;

  logic [XW-1:0]      d_ext;
  logic [XW-1:0]      up_raw;
  logic [XW-1:0]      dn_raw;
  logic [WIDTH-1:0]   up_val;
  logic [WIDTH-1:0]   dn_val;

  // Clamped faster/slower candidate values, computed one bit wider so the slow step cannot wrap.
  always_comb begin
    d_ext  = {1'b0, divider};
    up_raw = d_ext - (d_ext >> STEP_SHIFT);
    dn_raw = d_ext + (d_ext >> STEP_SHIFT) + XW'(1);
    up_val = (up_raw < {1'b0, MIN_DIV}) ? MIN_DIV : up_raw[WIDTH-1:0];
    dn_val = (dn_raw > {1'b0, MAX_DIV}) ? MAX_DIV : dn_raw[WIDTH-1:0];
  end

  // Next state and next divider; presses outrank dwell ticks, auto outranks up/down.
  always_comb begin
    state_nxt  = state;
    div_nxt    = divider;
    dwell_tick = (dwell_cnt == DW'(DWELL - 1));
    case (state)
      MANUAL: begin
        if (press_auto) begin
          state_nxt = AUTO_FAST;
        end else if (press_up && !press_dn) begin
          div_nxt = up_val;
        end else if (press_dn && !press_up) begin
          div_nxt = dn_val;
        end
      end
      AUTO_FAST, AUTO_SLOW: begin
        if (press_auto) begin
          state_nxt = MANUAL;
        end else if (press_up || press_dn) begin
          state_nxt = MANUAL;
          if (press_up && !press_dn) begin
            div_nxt = up_val;
          end else if (press_dn && !press_up) begin
            div_nxt = dn_val;
          end
        end else if (dwell_tick) begin
          if (state == AUTO_FAST) begin
            div_nxt = up_val;
            if (up_val == MIN_DIV) begin
              state_nxt = AUTO_SLOW;
            end
          end else begin
            div_nxt = dn_val;
            if (dn_val == MAX_DIV) begin
              state_nxt = AUTO_FAST;
            end
          end
        end
      end
      default: state_nxt = MANUAL;
    endcase
  end

  // Registered state, divider, update strobe, mode flag and dwell counter.
  always_ff @(posedge clk_src) begin
    if (reset) begin
      state       <= MANUAL;
      divider     <= RESET_DIV;
      div_update  <= 1'b0;
      auto_active <= 1'b0;
      dwell_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      divider     <= div_nxt;
      div_update  <= (div_nxt != divider);
      auto_active <= (state_nxt != MANUAL);
      if ((state_nxt != state) || dwell_tick || (state == MANUAL)) begin
        dwell_cnt <= '0;
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_knight_speed_ctrl.sv
// Directed, table-driven bench for knight_speed_ctrl with small simulation parameters.
module tb_knight_speed_ctrl;

  logic        clk_src  = 1'b0;
  logic        reset    = 1'b0;
  logic        btn_up   = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_auto = 1'b0;
  logic [23:0] divider;
  logic        div_update;
  logic        auto_active;

  knight_speed_ctrl #(
    .WIDTH      (24),
    .DEBOUNCE   (4),
    .DWELL      (8),
    .MIN_DIV    (24'd16),
    .MAX_DIV    (24'd1024),
    .RESET_DIV  (24'd256),
    .STEP_SHIFT (2)
  ) dut (
    .clk_src     (clk_src),
    .reset       (reset),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_auto    (btn_auto),
    .divider     (divider),
    .div_update  (div_update),
    .auto_active (auto_active)
  );

  always #5 clk_src = ~clk_src;

  int checks = 0;
  int errors = 0;
  int upd_total = 0;

  // Running count of div_update pulses, sampled on the inactive edge.
  always @(negedge clk_src) begin
    if (div_update) upd_total++;
  end

  typedef struct {
    bit rst;
    bit up;
    bit dn;
    bit toggle;
    int hold;
    int exp_div;
    int exp_upd;
  } vec_t;

  vec_t vecs[17];

  int sweep[30] = '{192, 144, 108, 81, 61, 46, 35, 27, 21, 16,
                    21, 27, 34, 43, 54, 68, 86, 108, 136, 171,
                    214, 268, 336, 421, 527, 659, 824, 1024, 768, 576};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_src);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic wait_update(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!div_update && n < 40);
  endtask

  task automatic wait_auto(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!auto_active && n < 40);
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    int u0;
    bit lvl;
    if (v.rst) do_reset();
    u0 = upd_total;
    for (int i = 0; i < v.hold; i++) begin
      lvl = v.toggle ? (((i / 2) % 2) == 0) : 1'b1;
      btn_up   = v.up & lvl;
      btn_down = v.dn & lvl;
      step(1);
    end
    btn_up   = 1'b0;
    btn_down = 1'b0;
    step(14);
    check($sformatf("vec%0d divider", idx), int'(divider), v.exp_div);
    check($sformatf("vec%0d updates", idx), upd_total - u0, v.exp_upd);
  endtask

  initial begin
    int n;
    int u0;
    int up_chain[9] = '{144, 108, 81, 61, 46, 35, 27, 21, 16};

    vecs[0] = '{rst: 1, up: 1, dn: 0, toggle: 0, hold: 20, exp_div: 192, exp_upd: 1};
    vecs[1] = '{rst: 0, up: 0, dn: 1, toggle: 0, hold: 20, exp_div: 241, exp_upd: 1};
    vecs[2] = '{rst: 1, up: 1, dn: 0, toggle: 1, hold: 30, exp_div: 256, exp_upd: 0};
    vecs[3] = '{rst: 0, up: 1, dn: 0, toggle: 0, hold: 5,  exp_div: 192, exp_upd: 1};
    vecs[4] = '{rst: 1, up: 1, dn: 0, toggle: 0, hold: 3,  exp_div: 256, exp_upd: 0};
    vecs[5] = '{rst: 1, up: 1, dn: 1, toggle: 0, hold: 20, exp_div: 256, exp_upd: 0};
    vecs[6] = '{rst: 1, up: 1, dn: 0, toggle: 0, hold: 10, exp_div: 192, exp_upd: 1};
    for (int i = 0; i < 9; i++) begin
      vecs[7 + i] = '{rst: 0, up: 1, dn: 0, toggle: 0, hold: 10, exp_div: up_chain[i], exp_upd: 1};
    end
    vecs[16] = '{rst: 0, up: 1, dn: 0, toggle: 0, hold: 10, exp_div: 16, exp_upd: 0};

    // Reset state
    step(1);
    do_reset();
    check("reset divider", int'(divider), 256);
    check("reset div_update", int'(div_update), 0);
    check("reset auto_active", int'(auto_active), 0);

    for (int i = 0; i < 17; i++) apply_vec(i, vecs[i]);

    // Auto sweep down to MIN, up to MAX and back, with exact dwell spacing
    do_reset();
    btn_auto = 1'b1;
    wait_auto(n);
    btn_auto = 1'b0;
    check("auto entry", int'(auto_active), 1);
    for (int i = 0; i < 30; i++) begin
      wait_update(n);
      check($sformatf("sweep%0d interval", i), n, 8);
      check($sformatf("sweep%0d divider", i), int'(divider), sweep[i]);
      check($sformatf("sweep%0d auto", i), int'(auto_active), 1);
    end

    // Down press coinciding with a dwell tick in AUTO_SLOW
    do_reset();
    btn_auto = 1'b1;
    wait_auto(n);
    btn_auto = 1'b0;
    for (int i = 0; i < 11; i++) wait_update(n);
    check("slow pre divider", int'(divider), 21);
    step(1);
    btn_down = 1'b1;
    u0 = upd_total;
    wait_update(n);
    check("collide latency", n, 7);
    check("collide divider", int'(divider), 27);
    check("collide auto", int'(auto_active), 0);
    step(3);
    btn_down = 1'b0;
    step(25);
    check("collide updates", upd_total - u0, 1);
    check("collide hold", int'(divider), 27);

    // Reset mid-sweep and mid-debounce
    do_reset();
    btn_auto = 1'b1;
    wait_auto(n);
    btn_auto = 1'b0;
    wait_update(n);
    wait_update(n);
    step(3);
    btn_up = 1'b1;
    step(3);
    reset  = 1'b1;
    btn_up = 1'b0;
    step(1);
    reset = 1'b0;
    check("midreset divider", int'(divider), 256);
    check("midreset auto", int'(auto_active), 0);
    check("midreset update", int'(div_update), 0);
    u0 = upd_total;
    step(25);
    check("midreset quiet", upd_total - u0, 0);
    check("midreset hold", int'(divider), 256);

    // Button held through reset yields one press afterwards
    btn_up = 1'b1;
    step(2);
    u0 = upd_total;
    do_reset();
    step(20);
    btn_up = 1'b0;
    step(14);
    check("held reset updates", upd_total - u0, 1);
    check("held reset divider", int'(divider), 192);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/knight_speed_ctrl.md
# knight_speed_ctrl

Speed and mode controller for the knight-rider LED scanner. It sits between the board buttons and the scanner's 24-bit `divider` input. It debounces three push-buttons and steps the divider value faster or slower in manual mode. In auto mode it sweeps the divider back and forth between two limits.

## Interface

Parameters:
- `WIDTH`, 24, divider width; matches the scanner's `divider` port.
- `DEBOUNCE`, 500000, clocks a synchronised button level must stay stable before it is accepted.
- `DWELL`, 2000000, clocks between divider steps in auto mode.
- `MIN_DIV`, 24'h010000, fastest allowed divider.
- `MAX_DIV`, 24'hfff000, slowest allowed divider.
- `RESET_DIV`, 24'h7fffff, divider after reset; `MIN_DIV <= RESET_DIV <= MAX_DIV`.
- `STEP_SHIFT`, 3, step size is `divider >> STEP_SHIFT`.

Ports (`clk_src` first):
- `clk_src  input  1`: sole clock; one clock; reset is synchronous and active-high.
- `reset  input  1`: synchronous, active-high reset, sampled on `posedge clk_src`.
- `btn_up  input  1`: raw asynchronous button, active-high; speeds the scan up.
- `btn_down  input  1`: raw asynchronous button, active-high; slows the scan down.
- `btn_auto  input  1`: raw asynchronous button, active-high; toggles auto mode.
- `divider  output  WIDTH`: registered divider value for the scanner.
- `div_update  output  1`: one-cycle pulse in the cycle `divider` takes a new value.
- `auto_active  output  1`: high while in `AUTO_FAST` or `AUTO_SLOW`.

## Operation

Button conditioning:
- Each button passes through a 2-flop synchroniser, then a debounce counter.
- The debounced level changes only after the synchronised level has differed from it for `DEBOUNCE` consecutive cycles.
- Any bounce restarts the counter.
- A rising edge of the debounced level produces a one-cycle press pulse. Releases produce nothing.

Step arithmetic:
- Computed at WIDTH+1 bits.
- Up: `d - (d >> STEP_SHIFT)`, clamped to at least `MIN_DIV`.
- Down: `d + (d >> STEP_SHIFT) + 1`, clamped to at most `MAX_DIV`; the +1 guarantees progress for small `d`.
- A clamped result equal to the current value is not an update, so `div_update` stays low.

FSM states: `MANUAL`, `AUTO_FAST`, `AUTO_SLOW`.
- `MANUAL`:
  - Up press: step up.
  - Down press: step down.
  - Up and down pressed in the same cycle: no change.
  - Auto press: go to `AUTO_FAST` and clear the dwell counter.
- `AUTO_FAST`: every `DWELL` cycles, step up. When the result equals `MIN_DIV`, go to `AUTO_SLOW`.
- `AUTO_SLOW`: every `DWELL` cycles, step down. When the result equals `MAX_DIV`, go to `AUTO_FAST`.
- Any auto state:
  - Auto press: go to `MANUAL`; `divider` is held.
  - Up or down press: go to `MANUAL` and apply that press in the same cycle.
  - A press outranks a dwell tick landing in the same cycle.
  - Simultaneous auto and up/down presses: auto wins and the up/down press is ignored.

Reset (any cycle, including mid-debounce or mid-sweep):
- `divider = RESET_DIV`, `div_update = 0`, `auto_active = 0`, state `MANUAL`.
- Synchronisers, debounce counters and debounced levels are cleared to 0.
- A button held through reset therefore produces one press once it has been stable for `DEBOUNCE` cycles.

## Timing

- Raw edge to press pulse: 2 cycles (synchroniser) + `DEBOUNCE` cycles, ±1 cycle for the asynchronous input.
- Press pulse to `divider` change and `div_update` high: 1 cycle; both are registered.
- Auto mode:
  - The first step happens `DWELL` cycles after entering `AUTO_FAST`.
  - Consecutive steps are exactly `DWELL` cycles apart.
  - The dwell counter restarts on every state change.
- `auto_active` is registered and changes in the same cycle as the state.

## Structure

- Package `knight_pkg`:
  - state enum `knight_ctrl_state_t` (`MANUAL`, `AUTO_FAST`, `AUTO_SLOW`);
  - the default constants for `MIN_DIV`, `MAX_DIV` and `RESET_DIV`;
  - `KNIGHT_DIV_W = 24`.
- Sub-module `button_debounce`:
  - parameter `DEBOUNCE`;
  - ports `clk_src`, `reset`, `btn`, `press`;
  - instantiated 3 times.
- The FSM, step arithmetic and dwell counter live in the top level.

## Test plan

Simulation parameters: `DEBOUNCE=4`, `DWELL=8`, `MIN_DIV=16`, `MAX_DIV=1024`, `RESET_DIV=256`, `STEP_SHIFT=2`.

1. Reset, then a clean 20-cycle up press -> exactly one `div_update`; `divider` goes 256 → 192. A down press then gives 192 → 241.
2. Up input toggling every 2 cycles for 30 cycles, then held low -> no press and `divider` stays 256. The same input held for 5 cycles -> one press.
3. Repeated up presses starting from 256 -> `divider` follows 192, 144, 108, 81, 61, 46, 35, 27, 21, 16. A further press -> `divider` stays 16 with no `div_update`.
4. Auto press -> `auto_active=1`, and `divider` steps every 8 cycles until it reaches 16. It then climbs to 1024 and descends again; the first step after each turnaround comes 8 cycles after the turnaround.
5. During `AUTO_SLOW`, a down press in the same cycle as a dwell tick -> one step only (the press). State becomes `MANUAL` and `auto_active=0`.
6. Reset asserted mid-sweep and mid-debounce -> next cycle `divider=256`, `auto_active=0`, `div_update=0`. No spurious press occurs while the button is released.
